pdm_mic_frontend: RTL and testbench
===================================

# pdm_mic_frontend

Upstream capture stage for the 16-microphone beamformer. Generates the shared PDM microphone clock and captures 8 stereo-paired PDM data lines (16 mics) on both clock phases. Decimates each channel with a first-order boxcar (CIC-1) accumulator and delivers frames of 16 signed PCM samples, channel 0 first, over a valid/ready stream into the beamformer core.

## Interface
- `CLK_DIV`, default 8: `clk` cycles per `pdm_clk` half-period (≥2).
- `DECIM_LOG2`, default 8: decimation is 2^DECIM_LOG2 PDM periods per output sample; also the output sample width.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `pdm_clk` out 1: microphone clock, registered, 50% duty.
- `pdm_data` in 8: bit i carries mic 2i (low phase) and mic 2i+1 (high phase).
- `sample_data` out DECIM_LOG2: signed two's-complement PCM sample.
- `sample_chan` out 4: channel index of `sample_data`.
- `sample_last` out 1: high with channel 15.
- `sample_valid` out 1: stream valid.
- `sample_ready` in 1: stream ready from beamformer.
- `overflow` out 1: sticky; a frame was dropped.

## Operation
- Reset values: `pdm_clk`=0, all accumulators=0, `sample_valid`=0, `sample_data`=0, `sample_chan`=0, `sample_last`=0, `overflow`=0, FSM=IDLE.
- Divider counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and `pdm_clk` toggles. Each PDM period is a low phase followed by a high phase.
- `pdm_data` passes through one input register (`pdm_q`). On the last cycle of a low phase, `pdm_q[i]` adds into accumulator 2i. On the last cycle of a high phase, it adds into accumulator 2i+1.
- Accumulators are unsigned, DECIM_LOG2 bits wide, one per channel.
- Period counter is DECIM_LOG2 bits. At the last cycle of the high phase that closes period 2^DECIM_LOG2, a snapshot fires:
  - each channel's count, including that cycle's bit, is offered to the frame buffer;
  - all accumulators clear to 0 for the next window.
- Sample value = count − 2^(DECIM_LOG2−1), computed modulo 2^DECIM_LOG2. 50% density gives 0. All-zeros gives −128 (default).
- FSM:
  - IDLE: on a snapshot, load the 16 values into the buffer, set idx=0, go to SEND.
  - SEND: present buffer[idx]. On `sample_valid && sample_ready`: if idx=15 go to IDLE, else idx+1.
- Snapshot while in SEND: the new frame is discarded, the buffer is untouched, and `overflow` is set.
- Snapshot in the same cycle as the channel-15 handshake: the new frame is accepted (the FSM re-enters SEND with idx=0); `overflow` is not set.

## Timing
- `sample_valid` rises the cycle after the snapshot. First frame: cycle 2·CLK_DIV·2^DECIM_LOG2 = 4096 (default) after reset release, counting the first clock edge as cycle 0.
- `sample_data`, `sample_chan` and `sample_last` are registered and stable while `sample_valid` is high and `sample_ready` is low.
- With `sample_ready` held high, one sample per cycle: a frame drains in 16 cycles. The next frame arrives 4096 cycles later.
- `sample_valid` never drops mid-frame.
- No combinational path from `sample_ready` to any output.
- Reset asserted mid-frame: all outputs return to their reset values immediately, the partial frame is lost, and `pdm_clk` restarts from its low phase.

## Configuration
- `PDM_SATURATE_EN` defined: a count of 2^DECIM_LOG2 (all ones for a full window) saturates to the maximum positive value, 0x7F by default. The accumulator gains one internal bit to hold the full count.
- Not defined: the accumulator wraps, so an all-ones window outputs −2^(DECIM_LOG2−1), 0x80 by default.
- All other values are identical with and without the macro.

## Test plan
- `pdm_data`=0x00, `sample_ready`=1 → at cycle 4096, 16 samples of 0x80, `sample_chan` 0..15, `sample_last` only on channel 15, `sample_valid` low at cycle 4112.
- `pdm_data`=0xFF → all samples 0x7F with `PDM_SATURATE_EN`, 0x80 without.
- Bit 0 high only during high phases, all other bits 0 → channel 1 = 0x7F (saturated build), channel 0 and channels 2..15 = 0x80. Bit 2 toggled every PDM period → channel 4 and channel 5 = 0x00.
- `sample_ready`=0 from reset → `sample_valid` high at 4096 with channel 0 data held stable. At the second snapshot (cycle 8192), `overflow`=1 and the buffer is unchanged. Raise `sample_ready` → the original frame drains in order, and the third snapshot (cycle 12288) is accepted.
- `sample_ready` toggling every cycle → 16 samples in order with no duplicates or skips. Channel-15 handshake aligned with a snapshot → new frame starts next cycle, `overflow`=0.
- `rst_n` pulsed low at idx=7 → all outputs at reset values during reset. After release, the first frame arrives 4096 cycles later.

Source files
------------

// File: rtl/pdm_mic_frontend.sv
// PDM microphone front end: shared mic clock, dual-phase capture of 8 stereo lines,
// CIC-1 decimation and a 16-sample frame stream. Optional macro: PDM_SATURATE_EN.
module pdm_mic_frontend #(
    parameter int CLK_DIV    = 8,
    parameter int DECIM_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  pdm_clk,
    input  logic [7:0]            pdm_data,
    output logic [DECIM_LOG2-1:0] sample_data,
    output logic [3:0]            sample_chan,
    output logic                  sample_last,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overflow,
    output logic                  dbg_state_o
);
`ifdef PDM_SATURATE_EN
    localparam int AW = DECIM_LOG2 + 1;
`else
    localparam int AW = DECIM_LOG2;
`endif
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    logic [DW-1:0]         div_q, div_d;
    logic                  pdm_clk_q, pdm_clk_d;
    logic [7:0]            pdm_q;
    logic [DECIM_LOG2-1:0] period_q, period_d;
    logic [AW-1:0]         acc_q [16];
    logic [AW-1:0]         acc_d [16];
    logic [AW-1:0]         cnt_w [16];
    logic [DECIM_LOG2-1:0] buf_q [16];
    logic [DECIM_LOG2-1:0] buf_d [16];
    state_t                state_q, state_d;
    logic [3:0]            idx_q, idx_d, idx_nx;
    logic                  valid_q, valid_d, last_q, last_d, ovf_q, ovf_d;
    logic [DECIM_LOG2-1:0] data_q, data_d;
    logic [3:0]            chan_q, chan_d;
    logic                  phase_end, snap, hs, frame_done;

    // Count of ones in a window -> signed PCM, offset by half scale.
    function automatic logic [DECIM_LOG2-1:0] to_pcm(input logic [AW-1:0] cnt);
`ifdef PDM_SATURATE_EN
        if (cnt[AW-1]) return {1'b0, {(DECIM_LOG2-1){1'b1}}};
`endif
        return {~cnt[DECIM_LOG2-1], cnt[DECIM_LOG2-2:0]};
    endfunction

    assign phase_end = (div_q == DW'(CLK_DIV - 1));
    assign snap      = phase_end && pdm_clk_q && (period_q == '1);
    assign idx_nx    = idx_q + 4'd1;
    // Stream: a sample moves when sample_valid && sample_ready at a clock edge; once raised,
    // valid and the payload hold until that handshake, and ready never reaches an output.
    assign hs         = valid_q && sample_ready;
    assign frame_done = (state_q == SEND) && hs && (idx_q == 4'd15);

    always_comb begin
        div_d     = phase_end ? '0 : div_q + DW'(1);
        pdm_clk_d = phase_end ? ~pdm_clk_q : pdm_clk_q;
        period_d  = (phase_end && pdm_clk_q) ? period_q + DECIM_LOG2'(1) : period_q;
        for (int i = 0; i < 8; i++) begin
            cnt_w[2*i]     = acc_q[2*i];
            cnt_w[2*i+1]   = acc_q[2*i+1] + AW'(pdm_q[i]);
            acc_d[2*i]     = acc_q[2*i];
            acc_d[2*i+1]   = acc_q[2*i+1];
            if (phase_end && !pdm_clk_q) acc_d[2*i]   = acc_q[2*i] + AW'(pdm_q[i]);
            if (phase_end && pdm_clk_q)  acc_d[2*i+1] = cnt_w[2*i+1];
            if (snap) begin
                acc_d[2*i]   = '0;
                acc_d[2*i+1] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: ;
            SEND: begin
                if (hs) begin
                    if (idx_q == 4'd15) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        idx_d  = idx_nx;
                        data_d = buf_q[idx_nx];
                        chan_d = idx_nx;
                        last_d = (idx_nx == 4'd15);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A finishing frame frees the buffer in time for a coincident snapshot.
        if (snap) begin
            if (state_q == IDLE || frame_done) begin
                for (int c = 0; c < 16; c++) buf_d[c] = to_pcm(cnt_w[c]);
                state_d = SEND;
                idx_d   = 4'd0;
                valid_d = 1'b1;
                data_d  = to_pcm(cnt_w[0]);
                chan_d  = 4'd0;
                last_d  = 1'b0;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
            pdm_q     <= '0;
            period_q  <= '0;
            acc_q     <= '{default: '0};
            buf_q     <= '{default: '0};
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            chan_q    <= '0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
            pdm_q     <= pdm_data;
            period_q  <= period_d;
            acc_q     <= acc_d;
            buf_q     <= buf_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pdm_clk      = pdm_clk_q;
    assign sample_data  = data_q;
    assign sample_chan  = chan_q;
    assign sample_last  = last_q;
    assign sample_valid = valid_q;
    assign overflow     = ovf_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Bench for pdm_mic_frontend: per-phase random/directed PDM data, a window-count model of the
// decimator and an expected-sample queue for the frame stream.
module tb_pdm_mic_frontend;
    localparam int CD  = 8;
    localparam int D   = 8;
    localparam int WIN = 2 * CD * (1 << D);

    logic         clk;
    logic         rst_n;
    logic         pdm_clk;
    logic [7:0]   pdm_data;
    logic [D-1:0] sample_data;
    logic [3:0]   sample_chan;
    logic         sample_last;
    logic         sample_valid;
    logic         sample_ready;
    logic         overflow;
    logic         dbg_state_o;

    pdm_mic_frontend #(.CLK_DIV(CD), .DECIM_LOG2(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pdm_clk      (pdm_clk),
        .pdm_data     (pdm_data),
        .sample_data  (sample_data),
        .sample_chan  (sample_chan),
        .sample_last  (sample_last),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .dbg_state_o  (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_ph = -1;
    int          dmode = 0;
    int          rmode = 1;
    int          cnt [16];
    logic        exp_ovf = 1'b0;
    logic [12:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [D-1:0] exp_pcm(input int c);
`ifdef PDM_SATURATE_EN
        if (c == (1 << D)) return D'((1 << (D - 1)) - 1);
`endif
        return D'((c - (1 << (D - 1))) & ((1 << D) - 1));
    endfunction

    // Data for one whole PDM phase; even phases are low, odd phases high.
    function automatic logic [7:0] gen_data(input int mode, input int ph);
        logic [7:0] v;
        v = 8'h00;
        case (mode)
            1: v = 8'hFF;
            2: v = 8'($urandom);
            3: v = {5'b0, ((ph / 2) % 2) == 1, 1'b0, (ph % 2) == 1};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        cyc     = 0;
        last_ph = -1;
        for (int c = 0; c < 16; c++) cnt[c] = 0;
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        pdm_data = 8'h00;
        #1;
        chk("rst_pdm_clk", 32'(pdm_clk), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_data", 32'(sample_data), 0);
        chk("rst_chan", 32'(sample_chan), 0);
        chk("rst_last", 32'(sample_last), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_state", 32'(dbg_state_o), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called at a negedge: check cycle cyc, drive inputs for the next edge, advance.
    task automatic tick();
        logic [12:0] e;
        logic        hs;
        int          ph;
        logic [7:0]  d;
        case (rmode)
            0: sample_ready = 1'b0;
            2: sample_ready = (cyc % 2) == 1;
            3: sample_ready = 1'($urandom_range(0, 1));
            4: sample_ready = (cyc % WIN) >= (WIN - 16);
            default: sample_ready = 1'b1;
        endcase
        chk("pdm_clk", 32'(pdm_clk), 32'((cyc / CD) % 2));
        chk("valid", 32'(sample_valid), 32'(exp_q.size() > 0));
        chk("state", 32'(dbg_state_o), 32'(exp_q.size() > 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        hs = (exp_q.size() > 0) && sample_ready;
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("data", 32'(sample_data), 32'(e[7:0]));
            chk("chan", 32'(sample_chan), 32'(e[11:8]));
            chk("last", 32'(sample_last), 32'(e[12]));
            if (hs) void'(exp_q.pop_front());
        end
        if ((cyc % WIN) == WIN - 1) begin
            if (exp_q.size() == 0) begin
                for (int c = 0; c < 16; c++) exp_q.push_back({c == 15, 4'(c), exp_pcm(cnt[c])});
            end else begin
                exp_ovf = 1'b1;
            end
            for (int c = 0; c < 16; c++) cnt[c] = 0;
        end
        ph = (cyc + 1) / CD;
        if (ph != last_ph) begin
            last_ph = ph;
            d = gen_data(dmode, ph);
            for (int i = 0; i < 8; i++) cnt[2 * i + (ph % 2)] += int'(d[i]);
            pdm_data = d;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_ready = 1'b0;
        pdm_data     = 8'h00;
        repeat (2) @(negedge clk);
        reset_dut();
        // Silence, then full scale, then the directed per-channel pattern, all with ready high.
        dmode = 0; rmode = 1; run(WIN);
        dmode = 1; rmode = 1; run(WIN);
        dmode = 3; rmode = 1; run(WIN);
        // Random data with ready toggling, then ready only in the last 16 cycles of each window
        // so the channel-15 handshake lands on the snapshot.
        dmode = 2; rmode = 2; run(WIN);
        dmode = 2; rmode = 4; run(2 * WIN);
        // Back-pressure across a snapshot drops a frame; draining lets the next one in.
        dmode = 2; rmode = 0; run(WIN);
        dmode = 2; rmode = 1; run(WIN);
        // Reset in the middle of a frame (idx 7), then a fresh start with random ready.
        run(7);
        reset_dut();
        dmode = 2; rmode = 3; run(WIN + 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
